// File: rtl/alu_pkg.sv
// Shared ALU encodings: op-code width, op-code values and requester id type.
// Also decoded to by alu_controller, so the values must stay fixed.
package alu_pkg;

   localparam int unsigned ALU_OP_W = 4;

   typedef logic [ALU_OP_W-1:0] alu_op_t;

   // 0: main pipeline EX slot, 1: auxiliary address/compare unit
   typedef logic req_id_t;

   localparam alu_op_t ALU_AND = 4'b0000;
   localparam alu_op_t ALU_OR  = 4'b0001;
   localparam alu_op_t ALU_ADD = 4'b0010;
   localparam alu_op_t ALU_SLL = 4'b0011;
   localparam alu_op_t ALU_SRL = 4'b0100;
   localparam alu_op_t ALU_SUB = 4'b0110;
   localparam alu_op_t ALU_SLT = 4'b0111;

endpackage

// File: rtl/alu_share_arbiter_shared_alu.sv
// Combinational shared ALU: one result per cycle for the issue-stage operands.
// Unknown op codes produce 0, and therefore zero=1.
module shared_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  alu_op_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result_c,
   output logic             zero_c
);

   logic [SHW-1:0] shamt;

   always_comb begin
      shamt    = b[SHW-1:0];
      result_c = '0;
      case (op)
         ALU_ADD: result_c = a + b;
         ALU_SUB: result_c = a - b;
         ALU_AND: result_c = a & b;
         ALU_OR:  result_c = a | b;
         ALU_SLT: result_c = WIDTH'($signed(a) < $signed(b));
         ALU_SLL: result_c = a << shamt;
         ALU_SRL: result_c = a >> shamt;
         default: result_c = '0;
      endcase
      zero_c = (result_c == '0);
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter and issue controller for the shared ALU (issue stage X, response stage R).
// Build option: ALU_ARB_RR_EN selects round-robin tie breaking; undefined gives fixed priority to r0.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  alu_op_t          r0_op,
   input  logic [WIDTH-1:0] r0_a,
   input  logic [WIDTH-1:0] r0_b,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  alu_op_t          r1_op,
   input  logic [WIDTH-1:0] r1_a,
   input  logic [WIDTH-1:0] r1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output req_id_t          rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero
);

   logic             x_valid_q, x_valid_d;
   req_id_t          x_id_q, x_id_d;
   alu_op_t          x_op_q, x_op_d;
   logic [WIDTH-1:0] x_a_q, x_a_d;
   logic [WIDTH-1:0] x_b_q, x_b_d;

   logic             rsp_valid_q, rsp_valid_d;
   req_id_t          rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_zero_q, rsp_zero_d;

`ifdef ALU_ARB_RR_EN
   req_id_t          last_grant_q, last_grant_d;
`endif

   logic             r_fire;
   logic             x_adv;
   logic             can_accept;
   logic             accept;
   req_id_t          grant;
   logic [WIDTH-1:0] alu_result_c;
   logic             alu_zero_c;

   shared_alu #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_alu (
      .op       (x_op_q),
      .a        (x_a_q),
      .b        (x_b_q),
      .result_c (alu_result_c),
      .zero_c   (alu_zero_c)
   );

   // Grant and handshake: ready depends only on valids, pipeline occupancy and rsp_ready.
   always_comb begin
      r_fire     = rsp_valid_q & rsp_ready;
      x_adv      = x_valid_q & (~rsp_valid_q | r_fire);
      can_accept = ~x_valid_q | x_adv;
`ifdef ALU_ARB_RR_EN
      grant      = (r0_valid & r1_valid) ? ~last_grant_q : req_id_t'(r1_valid);
`else
      grant      = req_id_t'(~r0_valid & r1_valid);
`endif
      accept     = rst_n & can_accept & (r0_valid | r1_valid);
      r0_ready   = accept & (grant == 1'b0);
      r1_ready   = accept & (grant == 1'b1);
   end

   // Next-state for the issue and response stages.
   always_comb begin
      x_valid_d    = x_valid_q;
      x_id_d       = x_id_q;
      x_op_d       = x_op_q;
      x_a_d        = x_a_q;
      x_b_d        = x_b_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
`ifdef ALU_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif

      if (accept) begin
         x_valid_d = 1'b1;
         x_id_d    = grant;
         x_op_d    = grant ? r1_op : r0_op;
         x_a_d     = grant ? r1_a  : r0_a;
         x_b_d     = grant ? r1_b  : r0_b;
`ifdef ALU_ARB_RR_EN
         last_grant_d = grant;
`endif
      end else if (x_adv) begin
         x_valid_d = 1'b0;
      end

      if (x_adv) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = x_id_q;
         rsp_result_d = alu_result_c;
         rsp_zero_d   = alu_zero_c;
      end else if (r_fire) begin
         rsp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_valid_q    <= 1'b0;
         x_id_q       <= 1'b0;
         x_op_q       <= '0;
         x_a_q        <= '0;
         x_b_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         x_valid_q    <= x_valid_d;
         x_id_q       <= x_id_d;
         x_op_q       <= x_op_d;
         x_a_q        <= x_a_d;
         x_b_q        <= x_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
`ifdef ALU_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;

endmodule
